// File: rtl/sort_pkg.sv
// sort_pkg: state type and default word width shared by the odd-even sorter
package sort_pkg;
   typedef enum logic [1:0] {LOAD, SORT, DRAIN} sort_state_t;
   localparam int SORT_W = 8;
endpackage

// File: rtl/cmp_swap_cell.sv
// cmp_swap_cell: combinational compare-swap of one adjacent pair; ties pass a to lo
module cmp_swap_cell
   import sort_pkg::*;
#(
   parameter int W       = SORT_W,
   parameter bit DESCEND = 1'b0
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] lo,
   output logic [W-1:0] hi
);
   logic w_swap;
   assign w_swap = DESCEND ? (b > a) : (a > b);
   assign lo     = w_swap ? b : a;
   assign hi     = w_swap ? a : b;
endmodule

// File: rtl/odd_even_sort_ctrl.sv
// odd_even_sort_ctrl: serial load, N odd-even transposition phases, serial drain
module odd_even_sort_ctrl
   import sort_pkg::*;
#(
   parameter int N       = 8,
   parameter int W       = SORT_W,
   parameter bit DESCEND = 1'b0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         in_ready,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   input  logic         out_ready,
   output logic         busy,
   output logic         sort_done
);
   localparam int CW = $clog2(N) + 1;
   sort_state_t   r_state;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] r_ph;
   logic [W-1:0]  r_mem [N];
   logic [W-1:0]  w_lo  [N-1];
   logic [W-1:0]  w_hi  [N-1];
   logic [W-1:0]  w_nxt [N];
   for (genvar g = 0; g < N - 1; g++) begin : g_cell
      cmp_swap_cell #(.W(W), .DESCEND(DESCEND)) u_cell (
         .a (r_mem[g]),
         .b (r_mem[g+1]),
         .lo(w_lo[g]),
         .hi(w_hi[g])
      );
   end
   // only cells whose left index matches the phase parity write back; the rest hold
   always_comb begin
      w_nxt = r_mem;
      for (int i = 0; i < N - 1; i++)
         if (i[0] == r_ph[0]) begin
            w_nxt[i]   = w_lo[i];
            w_nxt[i+1] = w_hi[i];
         end
   end
   assign in_ready  = r_state == LOAD;
   assign out_valid = r_state == DRAIN;
   assign busy      = r_state != LOAD;
   assign sort_done = (r_state == SORT) && (r_ph == CW'(N - 1));
   assign out_data  = out_valid ? r_mem[r_cnt[CW-2:0]] : '0;
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= LOAD;
         r_cnt   <= '0;
         r_ph    <= '0;
         r_mem   <= '{default: '0};
      end else begin
         case (r_state)
            LOAD: if (in_valid) begin
               r_mem[r_cnt[CW-2:0]] <= in_data;
               r_cnt   <= (r_cnt == CW'(N - 1)) ? '0 : r_cnt + CW'(1);
               r_ph    <= '0;
               r_state <= (r_cnt == CW'(N - 1)) ? SORT : LOAD;
            end
            SORT: begin
               r_mem   <= w_nxt;
               r_ph    <= r_ph + CW'(1);
               r_cnt   <= '0;
               r_state <= sort_done ? DRAIN : SORT;
            end
            DRAIN: if (out_ready) begin
               r_cnt   <= (r_cnt == CW'(N - 1)) ? '0 : r_cnt + CW'(1);
               r_state <= (r_cnt == CW'(N - 1)) ? LOAD : DRAIN;
            end
            default: r_state <= LOAD;
         endcase
      end
   end
endmodule

// File: tb/tb_odd_even_sort_ctrl.sv
// tb_odd_even_sort_ctrl: directed batches with hand-computed sorted outputs
module tb_odd_even_sort_ctrl;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = '0;
   logic       out_ready = 1'b0;
   logic       in_ready, out_valid, busy, sort_done;
   logic [7:0] out_data;
   logic       in_ready_d, out_valid_d, busy_d, sort_done_d;
   logic [7:0] out_data_d;
   int         n_checks = 0;
   int         n_fail = 0;

   logic [7:0] v_basic [8] = '{8'd9, 8'd12, 8'd15, 8'd3, 8'd0, 8'd255, 8'd7, 8'd12};
   logic [7:0] e_basic [8] = '{8'd0, 8'd3, 8'd7, 8'd9, 8'd12, 8'd12, 8'd15, 8'd255};
   logic [7:0] v_rev   [8] = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
   logic [7:0] v_fwd   [8] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
   logic [7:0] v_five  [8] = '{default: 8'd5};

   always #5 clk = ~clk;

   odd_even_sort_ctrl #(.N(8), .W(8), .DESCEND(1'b0)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
      .out_ready(out_ready), .busy(busy), .sort_done(sort_done)
   );
   // descending twin shares every input, so it moves through states in lockstep
   odd_even_sort_ctrl #(.N(8), .W(8), .DESCEND(1'b1)) dut_d (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready_d), .out_valid(out_valid_d), .out_data(out_data_d),
      .out_ready(out_ready), .busy(busy_d), .sort_done(sort_done_d)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      step();
      reset = 1'b1;
      check("rst_in_ready", in_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_sort_done", sort_done, 0);
      check("rst_out_data", out_data, 0);
   endtask

   task automatic load(input logic [7:0] v [8], input bit gap);
      for (int i = 0; i < 8; i++) begin
         if (gap && i == 1) begin
            in_valid = 1'b0;
            in_data  = 8'hEE;
            check("gap_in_ready", in_ready, 1);
            step();
         end
         in_valid = 1'b1;
         in_data  = v[i];
         check("load_in_ready", in_ready, 1);
         check("load_busy", busy, 0);
         step();
      end
      in_valid = 1'b0;
      in_data  = '0;
   endtask

   task automatic sort_phase(input bit junk);
      in_valid = junk;
      in_data  = junk ? 8'hAA : 8'h00;
      for (int k = 1; k <= 8; k++) begin
         check("sort_busy", busy, 1);
         check("sort_in_ready", in_ready, 0);
         check("sort_out_valid", out_valid, 0);
         check($sformatf("sort_done_k%0d", k), sort_done, (k == 8) ? 1 : 0);
         step();
      end
      check("first_out_valid", out_valid, 1);
      check("drain_sort_done", sort_done, 0);
   endtask

   task automatic drain(input logic [7:0] exp [8], input int stall_idx, input int stall_n,
                        input bit chk_d, input logic [7:0] exp_d [8]);
      int idx = 0;
      int stalls = stall_n;
      int guard = 0;
      while (idx < 8 && guard < 40) begin
         guard++;
         check("drain_out_valid", out_valid, 1);
         check("drain_in_ready", in_ready, 0);
         check($sformatf("out_data_%0d", idx), out_data, exp[idx]);
         if (chk_d) check($sformatf("out_data_desc_%0d", idx), out_data_d, exp_d[idx]);
         out_ready = !(idx == stall_idx && stalls > 0);
         if (!out_ready) stalls--;
         step();
         if (out_ready) idx++;
      end
      check("drain_complete", idx, 8);
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      check("post_in_ready", in_ready, 1);
      check("post_busy", busy, 0);
      check("post_out_valid", out_valid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end

   initial begin
      step();
      do_reset();
      // basic ascending batch
      load(v_basic, 1'b0);
      sort_phase(1'b0);
      drain(e_basic, -1, 0, 1'b0, v_fwd);
      // reversed input, gapped load, junk driven through SORT and DRAIN
      load(v_rev, 1'b1);
      sort_phase(1'b1);
      in_valid = 1'b1;
      in_data  = 8'hAA;
      drain(v_fwd, -1, 0, 1'b0, v_fwd);
      // backpressure on word index 2 for three cycles
      load(v_basic, 1'b0);
      sort_phase(1'b0);
      drain(e_basic, 2, 3, 1'b0, v_fwd);
      // back-to-back batch, also checks the descending twin
      load(v_fwd, 1'b0);
      sort_phase(1'b0);
      drain(v_fwd, -1, 0, 1'b1, v_rev);
      // reset during SORT phase 3, then an all-equal batch
      load(v_rev, 1'b0);
      step();
      step();
      step();
      check("midsort_busy", busy, 1);
      do_reset();
      load(v_five, 1'b0);
      sort_phase(1'b0);
      drain(v_five, -1, 0, 1'b0, v_fwd);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
